// File: rtl/seg_pkg.sv
// Segment-level constants shared by the single-digit encoder and the scan multiplexer.
// Patterns are {a,b,c,d,e,f,g,dp} with segment a in the MSB, active-high.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic {
      PHASE_BLANK,
      PHASE_DRIVE
   } slot_phase_e;

   function automatic logic [7:0] seg_digit(input logic [3:0] value);
      logic [7:0] pattern;
      case (value)
         4'd0:    pattern = 8'hFC;
         4'd1:    pattern = 8'h60;
         4'd2:    pattern = 8'hDA;
         4'd3:    pattern = 8'hF2;
         4'd4:    pattern = 8'h66;
         4'd5:    pattern = 8'hB6;
         4'd6:    pattern = 8'hBE;
         4'd7:    pattern = 8'hE0;
         4'd8:    pattern = 8'hFE;
         4'd9:    pattern = 8'hE6;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/digit position counters for the display scan. The counters hold the frame
// position being consumed by the current edge, so decodes here are combinational.
module scan_timer #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 1000,
   parameter int BLANK      = 50,
   localparam int SW        = $clog2(DIV),
   localparam int DW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [DW-1:0] digit_o,
   output logic          in_blank_o,
   output logic          frame_end_o
);

   localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
   localparam logic [SW-1:0] BLANK_END  = SW'(BLANK);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

   logic [SW-1:0] slot_q, slot_d;
   logic [DW-1:0] digit_q, digit_d;
   logic          slot_last;

   assign slot_last   = (slot_q == SLOT_LAST);
   assign digit_o     = digit_q;
   assign in_blank_o  = (slot_q < BLANK_END);
   assign frame_end_o = slot_last && (digit_q == DIGIT_LAST);

   // Both counters clear on an explicit compare so non-power-of-two sizes never wrap naturally.
   always_comb begin
      slot_d  = slot_q + SW'(1);
      digit_d = digit_q;
      if (slot_last) begin
         slot_d = '0;
         if (digit_q == DIGIT_LAST) begin
            digit_d = '0;
         end else begin
            digit_d = digit_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q  <= '0;
         digit_q <= '0;
      end else begin
         slot_q  <= slot_d;
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: double-buffered frame load, per-slot blanking
// to avoid ghosting, registered segment bus and digit selects.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DIV            = 1000,
   parameter int BLANK          = 50,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [8*NUM_DIGITS-1:0] load_data,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_done
);

   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

   if (NUM_DIGITS < 1 || DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
      $error("seg_scan_mux: illegal NUM_DIGITS/DIV/BLANK combination");
   end

   logic [DW-1:0]             digit;
   logic                      in_blank;
   logic                      frame_end;
   slot_phase_e               phase;

   logic [8*NUM_DIGITS-1:0]   active_q, active_d;
   logic [8*NUM_DIGITS-1:0]   pend_q, pend_d;
   logic                      pending_q, pending_d;
   logic [7:0]                seg_q, seg_d;
   logic [NUM_DIGITS-1:0]     sel_q, sel_d;
   logic                      done_q, done_d;
   logic [NUM_DIGITS-1:0]     onehot;
   logic [7:0]                digit_seg;

   scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIV        (DIV),
      .BLANK      (BLANK)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .digit_o     (digit),
      .in_blank_o  (in_blank),
      .frame_end_o (frame_end)
   );

   assign load_ready = ~pending_q;
   assign seg_out    = seg_q;
   assign dig_sel    = sel_q;
   assign frame_done = done_q;

   // Swap only at a frame boundary; a load can only land when nothing is pending,
   // so the swap and the capture never touch the pending flag on the same edge.
   always_comb begin
      active_d  = active_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      if (frame_end && pending_q) begin
         active_d  = pend_q;
         pending_d = 1'b0;
      end
      if (load_valid && !pending_q) begin
         pend_d    = load_data;
         pending_d = 1'b1;
      end
   end

   always_comb begin
      onehot    = '0;
      digit_seg = SEG_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit == DW'(i)) begin
            onehot[i] = 1'b1;
            digit_seg = active_q[8*i +: 8];
         end
      end
      phase  = in_blank ? PHASE_BLANK : PHASE_DRIVE;
      seg_d  = SEG_BLANK;
      sel_d  = SEL_IDLE;
      done_d = frame_end;
      case (phase)
         PHASE_DRIVE: begin
            seg_d = digit_seg;
            sel_d = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q  <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         sel_q     <= SEL_IDLE;
         done_q    <= 1'b0;
      end else begin
         active_q  <= active_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         sel_q     <= sel_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: one active-low and one active-high instance share
// the same stimulus (4 digits, 10 clocks per slot, 2 blank clocks).
module tb_seg_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [31:0] load_data;

   logic        readyA, doneA, readyB, doneB;
   logic [7:0]  segA, segB;
   logic [3:0]  selA, selB;

   int checks = 0;
   int errors = 0;

   seg_scan_mux #(.NUM_DIGITS(4), .DIV(10), .BLANK(2), .SEL_ACTIVE_LOW(1)) dutA (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (readyA),
      .load_data  (load_data),
      .seg_out    (segA),
      .dig_sel    (selA),
      .frame_done (doneA)
   );

   seg_scan_mux #(.NUM_DIGITS(4), .DIV(10), .BLANK(2), .SEL_ACTIVE_LOW(0)) dutB (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (readyB),
      .load_data  (load_data),
      .seg_out    (segB),
      .dig_sel    (selB),
      .frame_done (doneB)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      load_data = 32'h0;
      repeat (3) step();
      checks++;
      if (segA !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_seg: got %h expected 00", segA);
      end
      checks++;
      if (selA !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL reset_sel_low: got %b expected 1111", selA);
      end
      checks++;
      if (selB !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_sel_high: got %b expected 0000", selB);
      end
      checks++;
      if (doneA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_done: got %b expected 0", doneA);
      end
      checks++;
      if (readyA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected 1", readyA);
      end
   endtask

   // Windowed checks on both instances; ready and frame_done are checked every edge.
   task automatic test_load_and_swap();
      logic [7:0] es;
      logic [3:0] ea, eb;
      logic       er, ed, chk;
      rst = 1'b0;
      load_valid = 1'b1;
      load_data = 32'hE6FEE0BE;
      step();
      load_valid = 1'b0;
      checks++;
      if (readyA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_accept_ready: got %b expected 0", readyA);
      end
      for (int e = 1; e <= 79; e++) begin
         if (e == 5) begin
            load_valid = 1'b1;
            load_data = 32'h11111111;
         end
         if (e == 6) load_valid = 1'b0;
         step();
         er = (e >= 39);
         ed = (e == 39 || e == 79);
         chk = 1'b1;
         es = 8'h00; ea = 4'b1111; eb = 4'b0000;
         case (e)
            2, 5, 9: begin es = 8'h00; ea = 4'b1110; eb = 4'b0001; end
            20:      begin es = 8'h00; ea = 4'b1111; eb = 4'b0000; end
            22, 29:  begin es = 8'h00; ea = 4'b1011; eb = 4'b0100; end
            40, 41:  begin es = 8'h00; ea = 4'b1111; eb = 4'b0000; end
            42, 49:  begin es = 8'hBE; ea = 4'b1110; eb = 4'b0001; end
            52:      begin es = 8'hE0; ea = 4'b1101; eb = 4'b0010; end
            62:      begin es = 8'hFE; ea = 4'b1011; eb = 4'b0100; end
            72, 79:  begin es = 8'hE6; ea = 4'b0111; eb = 4'b1000; end
            default: chk = 1'b0;
         endcase
         checks++;
         if (readyA !== er) begin
            errors++;
            $display("[TB] FAIL swap_ready p=%0d: got %b expected %b", e, readyA, er);
         end
         checks++;
         if (doneA !== ed || doneB !== ed) begin
            errors++;
            $display("[TB] FAIL swap_done p=%0d: got %b/%b expected %b", e, doneA, doneB, ed);
         end
         if (chk) begin
            checks++;
            if (segA !== es || segB !== es) begin
               errors++;
               $display("[TB] FAIL swap_seg p=%0d: got %h/%h expected %h", e, segA, segB, es);
            end
            checks++;
            if (selA !== ea || selB !== eb) begin
               errors++;
               $display("[TB] FAIL swap_sel p=%0d: got %b/%b expected %b/%b", e, selA, selB, ea, eb);
            end
         end
      end
   endtask

   // A load landing on the boundary edge with nothing pending waits one extra frame.
   task automatic test_load_at_boundary();
      logic [7:0] es;
      logic [3:0] ea;
      logic       er, ed, chk;
      for (int e = 80; e <= 199; e++) begin
         if (e == 119) begin
            load_valid = 1'b1;
            load_data = 32'h60606060;
         end
         if (e == 120) load_valid = 1'b0;
         step();
         er = !(e >= 119 && e < 159);
         ed = ((e % 40) == 39);
         chk = 1'b1;
         es = 8'h00; ea = 4'b1111;
         case (e)
            82, 122:  begin es = 8'hBE; ea = 4'b1110; end
            132:      begin es = 8'hE0; ea = 4'b1101; end
            160:      begin es = 8'h00; ea = 4'b1111; end
            162, 169: begin es = 8'h60; ea = 4'b1110; end
            192:      begin es = 8'h60; ea = 4'b0111; end
            default:  chk = 1'b0;
         endcase
         checks++;
         if (readyA !== er) begin
            errors++;
            $display("[TB] FAIL bound_ready p=%0d: got %b expected %b", e, readyA, er);
         end
         checks++;
         if (doneA !== ed) begin
            errors++;
            $display("[TB] FAIL bound_done p=%0d: got %b expected %b", e, doneA, ed);
         end
         if (chk) begin
            checks++;
            if (segA !== es || selA !== ea) begin
               errors++;
               $display("[TB] FAIL bound_out p=%0d: got %h/%b expected %h/%b", e, segA, selA, es, ea);
            end
         end
      end
   endtask

   // Reset lands on the edge that would have been p=25 of a frame showing 60 everywhere.
   task automatic test_reset_mid_frame();
      logic [7:0] es;
      logic [3:0] ea, eb;
      logic       ed, chk;
      for (int e = 200; e <= 224; e++) step();
      checks++;
      if (segA !== 8'h60 || selA !== 4'b1011) begin
         errors++;
         $display("[TB] FAIL pre_reset_out: got %h/%b expected 60/1011", segA, selA);
      end
      rst = 1'b1;
      load_valid = 1'b1;
      load_data = 32'hAAAAAAAA;
      step();
      checks++;
      if (segA !== 8'h00 || selA !== 4'b1111 || selB !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL mid_reset_out: got %h/%b/%b expected 00/1111/0000", segA, selA, selB);
      end
      checks++;
      if (doneA !== 1'b0 || readyA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset_flags: got done %b ready %b expected 0/1", doneA, readyA);
      end
      step();
      checks++;
      if (readyA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ignores_load: got %b expected 1", readyA);
      end
      rst = 1'b0;
      load_valid = 1'b0;
      for (int e = 0; e <= 42; e++) begin
         step();
         ed = (e == 39);
         chk = 1'b1;
         es = 8'h00; ea = 4'b1111; eb = 4'b0000;
         case (e)
            0:       begin ea = 4'b1111; eb = 4'b0000; end
            2:       begin ea = 4'b1110; eb = 4'b0001; end
            12:      begin ea = 4'b1101; eb = 4'b0010; end
            22:      begin ea = 4'b1011; eb = 4'b0100; end
            32:      begin ea = 4'b0111; eb = 4'b1000; end
            42:      begin ea = 4'b1110; eb = 4'b0001; end
            default: chk = 1'b0;
         endcase
         checks++;
         if (doneA !== ed || readyA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_flags p=%0d: got done %b ready %b expected %b/1", e, doneA, readyA, ed);
         end
         if (chk) begin
            checks++;
            if (segA !== es || selA !== ea || selB !== eb) begin
               errors++;
               $display("[TB] FAIL restart_out p=%0d: got %h/%b/%b expected %h/%b/%b",
                        e, segA, selA, selB, es, ea, eb);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_and_swap();
      test_load_at_boundary();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
